// File: rtl/led_blinker.sv
// Free-running LED blinker for board bring-up.
// Toggles led once every PERIOD clk cycles (square wave, period 2*PERIOD).
module led_blinker #(
   parameter int PERIOD = 100,
   parameter int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
   input  logic clk,
   input  logic reset,
   output logic led
);

   // Terminal count; the explicit compare governs wrap even for
   // power-of-two PERIOD, so natural overflow is never relied on.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   // Power-up values keep led at 0 from time 0 even without a reset.
   logic [CNT_W-1:0] cnt   = '0;
   logic             led_q = 1'b0;

   // Cycle counter and led toggle register, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         led_q <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         led_q <= ~led_q;
      end else begin
         cnt   <= cnt + ONE;
      end
   end

   assign led = led_q;

endmodule

// File: tb/tb_led_blinker.sv
// Self-checking bench for led_blinker: PERIOD=100, 1 and 7 instances
// checked edge by edge against a reference model through a scoreboard.
module tb_led_blinker;

   typedef struct {
      int   id;
      logic exp;
   } sb_t;

   logic clk = 1'b0;
   logic rst100 = 1'b0;
   logic rst1 = 1'b0;
   logic rst7 = 1'b0;
   logic led100;
   logic led1;
   logic led7;

   int total = 0;
   int bad = 0;

   sb_t sbq[$];

   int   m_cnt[3];
   logic m_led[3];
   int   per[3];

   int   edge_n = 0;
   logic prev[3];
   int   chg100 = 0;
   int   chg1 = 0;
   int   chg7 = 0;
   int   last7 = 0;

   led_blinker #(.PERIOD(100)) u100 (.clk(clk), .reset(rst100), .led(led100));
   led_blinker #(.PERIOD(1))   u1   (.clk(clk), .reset(rst1),   .led(led1));
   led_blinker #(.PERIOD(7))   u7   (.clk(clk), .reset(rst7),   .led(led7));

   // 20 ns system clock
   always #10 clk = ~clk;

   function automatic logic obs(input int id);
      case (id)
         0: return led100;
         1: return led1;
         default: return led7;
      endcase
   endfunction

   function automatic logic rst_of(input int id);
      case (id)
         0: return rst100;
         1: return rst1;
         default: return rst7;
      endcase
   endfunction

   // One clk edge: advance the models, push expectations, compare at negedge.
   task automatic step(input bit rst_at_edge);
      sb_t e;
      @(posedge clk);
      if (rst_at_edge) rst100 = 1'b1;
      edge_n++;
      for (int i = 0; i < 3; i++) begin
         if (rst_of(i)) begin
            m_cnt[i] = 0;
            m_led[i] = 1'b0;
         end else if (m_cnt[i] == per[i] - 1) begin
            m_cnt[i] = 0;
            m_led[i] = ~m_led[i];
         end else begin
            m_cnt[i] = m_cnt[i] + 1;
         end
         e.id = i;
         e.exp = m_led[i];
         sbq.push_back(e);
      end
      @(negedge clk);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         total++;
         if (obs(e.id) !== e.exp) begin
            bad++;
            $display("FAIL sb_led%0d edge=%0d got=%b exp=%b",
                     e.id, edge_n, obs(e.id), e.exp);
         end
      end
      total++;
      if (u7.cnt >= 3'd7) begin
         bad++;
         $display("FAIL cnt7_bound edge=%0d got=%0d exp<7", edge_n, u7.cnt);
      end
      if (led100 !== prev[0]) chg100++;
      if (edge_n <= 50 && led1 !== prev[1]) chg1++;
      if (edge_n <= 70 && led7 !== prev[2]) begin
         chg7++;
         total++;
         if (edge_n - last7 != 7) begin
            bad++;
            $display("FAIL spacing7 edge=%0d got=%0d exp=7",
                     edge_n, edge_n - last7);
         end
         last7 = edge_n;
      end
      prev[0] = led100;
      prev[1] = led1;
      prev[2] = led7;
   endtask

   task automatic test_reset;
      #1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs(i) !== 1'b0) begin
            bad++;
            $display("FAIL powerup_led%0d got=%b exp=0", i, obs(i));
         end
      end
   endtask

   task automatic test_free_run;
      logic exp;
      for (int k = 1; k <= 500; k++) begin
         step(1'b0);
         if (k % 100 == 0) begin
            exp = ((k / 100) % 2 == 1);
            total++;
            if (led100 !== exp) begin
               bad++;
               $display("FAIL free_led100 edge=%0d got=%b exp=%b",
                        k, led100, exp);
            end
         end
         if (k < 100) begin
            total++;
            if (led100 !== 1'b0) begin
               bad++;
               $display("FAIL powerup_hold edge=%0d got=%b exp=0", k, led100);
            end
         end
      end
      total++;
      if (chg100 != 5) begin
         bad++;
         $display("FAIL chg100 got=%0d exp=5", chg100);
      end
      total++;
      if (chg1 != 50) begin
         bad++;
         $display("FAIL chg1 got=%0d exp=50", chg1);
      end
      total++;
      if (chg7 != 10) begin
         bad++;
         $display("FAIL chg7 got=%0d exp=10", chg7);
      end
   endtask

   // Wait for the next rising led100; bounded, returns edges taken.
   task automatic wait_rise(output int n);
      n = 0;
      for (int k = 1; k <= 300; k++) begin
         step(1'b0);
         if (led100 === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic test_hold_reset;
      int n;
      #3;
      rst100 = 1'b1;
      m_cnt[0] = 0;
      m_led[0] = 1'b0;
      #1;
      total++;
      if (led100 !== 1'b0) begin
         bad++;
         $display("FAIL rst_immediate got=%b exp=0", led100);
      end
      for (int k = 0; k < 3; k++) step(1'b0);
      #3;
      rst100 = 1'b0;
      prev[0] = led100;
      wait_rise(n);
      total++;
      if (n != 100) begin
         bad++;
         $display("FAIL first_rise got=%0d exp=100", n);
      end
   endtask

   task automatic test_async_pulse;
      int n;
      for (int k = 0; k < 50; k++) step(1'b0);
      total++;
      if (led100 !== 1'b1) begin
         bad++;
         $display("FAIL led_at_150 got=%b exp=1", led100);
      end
      #3;
      rst100 = 1'b1;
      m_cnt[0] = 0;
      m_led[0] = 1'b0;
      #1;
      total++;
      if (led100 !== 1'b0) begin
         bad++;
         $display("FAIL async_drop got=%b exp=0", led100);
      end
      #2;
      rst100 = 1'b0;
      prev[0] = led100;
      wait_rise(n);
      total++;
      if (n != 100) begin
         bad++;
         $display("FAIL rise_after_pulse got=%0d exp=100", n);
      end
   endtask

   task automatic test_reset_at_edge;
      int n;
      for (int k = 0; k < 40; k++) step(1'b0);
      step(1'b1);
      total++;
      if (led100 !== 1'b0 || u100.cnt !== 7'd0) begin
         bad++;
         $display("FAIL edge_reset got=%b/%0d exp=0/0", led100, u100.cnt);
      end
      #3;
      rst100 = 1'b0;
      prev[0] = led100;
      wait_rise(n);
      total++;
      if (n != 100) begin
         bad++;
         $display("FAIL rise_after_edge_rst got=%0d exp=100", n);
      end
      for (int k = 0; k < 120; k++) step(1'b0);
   endtask

   initial begin
      per[0] = 100;
      per[1] = 1;
      per[2] = 7;
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_led[i] = 1'b0;
         prev[i] = 1'b0;
      end
      test_reset;
      test_free_run;
      test_hold_reset;
      test_async_pulse;
      test_reset_at_edge;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_blinker.md
Name: led_blinker

Overview:
- Free-running LED blinker: divides the system clock and toggles a single LED output once every PERIOD clock cycles.
- Produces a square wave with a period of 2*PERIOD clocks and 50% duty cycle.
- Leaf block for board bring-up. Drives the board LED pin directly from the system clock domain.

Parameters:
- PERIOD, default 100, number of clk rising edges between consecutive led toggles. Legal range is an integer >= 1.
- CNT_W, default $clog2(PERIOD) (minimum 1), width of the internal cycle counter. Derived from PERIOD and not overridden by users.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous active-high reset; clears counter and led.
- led  output  1  blink output, registered, toggles every PERIOD cycles.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset).
- State consists of:
  - counter cnt[CNT_W-1:0], counting 0..PERIOD-1;
  - register led_q, which drives led directly with no combinational path.
- Reset:
  - While reset=1, cnt=0 and led=0, effective immediately without waiting for a clock edge.
  - Asserting reset mid-count aborts the count. After release, counting restarts from 0.
- Power-up:
  - cnt and led_q carry initial values of 0, so a bench that never asserts reset still sees led=0 from time 0 (no X).
  - led must not change value at time 0.
- On each clk rising edge with reset=0:
  - If cnt == PERIOD-1: cnt <= 0 and led_q <= ~led_q.
  - Otherwise: cnt <= cnt + 1 and led_q holds.
- Latency: the first toggle occurs on the PERIOD-th rising edge after reset deassertion (or after time 0 if never reset). Subsequent toggles occur every PERIOD edges.
- Toggle count: over N rising edges from reset release, led changes exactly floor(N/PERIOD) times. Example: PERIOD=100 with 500 edges gives 5 changes.
- PERIOD=1: led toggles on every rising edge, giving a clk/2 square wave. cnt stays 0.
- Wrap-around:
  - cnt never exceeds PERIOD-1.
  - When PERIOD is a power of two, the explicit compare still governs; natural counter overflow is not relied on.
- led is glitch-free and changes only on a clk rising edge or on assertion of reset.
- Reset asserted exactly at a clock edge: reset wins, so cnt=0 and led=0.

Test Plan:
- PERIOD=100, 20 ns clk, reset never asserted, run 10000 ns (500 edges) -> exactly 5 led changes; led=1 after edges 100, 300, 500 and led=0 after edges 200, 400.
- PERIOD=100, reset=1 for 3 cycles, then release -> led=0 throughout reset; first rise exactly on the 100th edge after release; then period 200 clk with 50% duty.
- Reset pulsed asynchronously between edges at edge 150 while led=1 -> led drops to 0 immediately without a clock edge; next toggle occurs 100 edges after release.
- PERIOD=1, 50 edges -> led toggles on every edge, giving 50 changes and a clk/2 waveform.
- PERIOD=7 (non-power-of-two), 70 edges -> 10 toggles spaced exactly 7 edges apart; cnt never observed >= 7.
- Power-up check, no reset -> led is 0 (not X) at time 0+ and stays 0 until edge PERIOD.
